// File: rtl/marquee_if.sv
// Bundle between the marquee controller and the board: debounced buttons and
// visible characters come in, rotate/load strobes and the digit scan go out.
interface marquee_if #(
    parameter int CHAR_W = 4
);
    logic              btn_pause;
    logic              btn_step;
    logic              btn_dir;
    logic              btn_reload;
    logic [CHAR_W-1:0] char0;
    logic [CHAR_W-1:0] char1;
    logic [CHAR_W-1:0] char2;
    logic [CHAR_W-1:0] char3;
    logic              shift_en;
    logic              shift_dir;
    logic              load;
    logic [3:0]        digit_sel;
    logic [CHAR_W-1:0] digit_code;
    logic [1:0]        state;

    // Controller side: reads buttons and characters, drives strobes and scan.
    modport master (
        input  btn_pause, btn_step, btn_dir, btn_reload,
        input  char0, char1, char2, char3,
        output shift_en, shift_dir, load, digit_sel, digit_code, state
    );

    // Board / datapath side.
    modport slave (
        output btn_pause, btn_step, btn_dir, btn_reload,
        output char0, char1, char2, char3,
        input  shift_en, shift_dir, load, digit_sel, digit_code, state
    );
endinterface

// File: rtl/marquee_ctrl.sv
// Marquee sequencer: synchronizes the buttons, runs the IDLE/LOAD/RUN/PAUSE
// state machine that strobes the rotating register, and scans the four
// seven-segment digits over one shared code bus.
module marquee_ctrl #(
    parameter int STEP_DIV = 25000000,
    parameter int SCAN_DIV = 100000,
    parameter int CHAR_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    marquee_if.master  bus
);

    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    // Button bit order: {reload, dir, step, pause}
    logic [3:0] btn_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;
    logic [3:0] pulse;
    logic       pause_pulse;
    logic       step_pulse;
    logic       dir_pulse;
    logic       reload_pulse;

    state_e            state_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic              shift_en_q;
    logic              shift_dir_q;
    logic              load_q;

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_d;
    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic [3:0]        digit_sel_q;
    logic [3:0]        digit_sel_d;
    logic [CHAR_W-1:0] digit_code_q;
    logic [CHAR_W-1:0] digit_code_d;
    logic              scan_wrap;

    assign btn_raw = {bus.btn_reload, bus.btn_dir, bus.btn_step, bus.btn_pause};

    // Two-flop synchronizer followed by an edge-detect flop for every button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A pulse lasts one cycle however long the button stays high.
    assign pulse        = sync2_q & ~prev_q;
    assign pause_pulse  = pulse[0];
    assign step_pulse   = pulse[1];
    assign dir_pulse    = pulse[2];
    assign reload_pulse = pulse[3];

    // Sequencer FSM with step timer; reload beats pause beats step, and the
    // losers are dropped. Direction toggles independently outside IDLE/LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            shift_en_q  <= 1'b0;
            shift_dir_q <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            shift_en_q <= 1'b0;
            load_q     <= 1'b0;
            step_cnt_q <= '0;
            if (dir_pulse && (state_q == RUN || state_q == PAUSE)) begin
                shift_dir_q <= ~shift_dir_q;
            end
            case (state_q)
                IDLE: begin
                    state_q <= LOAD;
                    load_q  <= 1'b1;
                end
                LOAD: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (reload_pulse) begin
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                    end else if (pause_pulse) begin
                        state_q <= PAUSE;
                    end else if (step_cnt_q == STEP_LAST) begin
                        shift_en_q <= 1'b1;
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end
                PAUSE: begin
                    if (reload_pulse) begin
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                    end else if (pause_pulse) begin
                        state_q <= RUN;
                    end else if (step_pulse) begin
                        shift_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Scan next-state: the code is picked with the index being loaded this
    // cycle so digit_sel and digit_code always switch on the same edge.
    always_comb begin
        scan_wrap    = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d        = scan_wrap ? idx_q + 2'd1 : idx_q;
        digit_sel_d  = ~(4'b0001 << idx_d);
        digit_code_d = '0;
        case (idx_d)
            2'd0:    digit_code_d = bus.char0;
            2'd1:    digit_code_d = bus.char1;
            2'd2:    digit_code_d = bus.char2;
            default: digit_code_d = bus.char3;
        endcase
    end

    // Scan registers run continuously outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q   <= '0;
            idx_q        <= 2'd0;
            digit_sel_q  <= 4'b1110;
            digit_code_q <= '0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            digit_sel_q  <= digit_sel_d;
            digit_code_q <= digit_code_d;
        end
    end

    assign bus.shift_en   = shift_en_q;
    assign bus.shift_dir  = shift_dir_q;
    assign bus.load       = load_q;
    assign bus.state      = state_q;
    assign bus.digit_sel  = digit_sel_q;
    assign bus.digit_code = digit_code_q;

endmodule

// File: tb/tb_marquee_ctrl.sv
// Directed bench for marquee_ctrl with STEP_DIV=4, SCAN_DIV=2, CHAR_W=4.
module tb_marquee_ctrl;

    localparam int STEP_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int CHAR_W   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks  = 0;
    int   errors  = 0;
    int   sen_cnt = 0;
    int   ld_cnt  = 0;
    int   n;

    // Expected outputs for the first ten edges after reset release
    // (chars 2,3,1,4; digit changes every 2 cycles; first strobe 4 cycles into RUN).
    logic [1:0] exp_st  [10] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic       exp_ld  [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_sen [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_sel [10] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                                 4'b0111, 4'b0111, 4'b1110, 4'b1110, 4'b1101};
    logic [3:0] exp_cod [10] = '{4'd2, 4'd3, 4'd3, 4'd1, 4'd1, 4'd4, 4'd4, 4'd2, 4'd2, 4'd3};

    marquee_if #(.CHAR_W(CHAR_W)) bus ();

    marquee_ctrl #(
        .STEP_DIV(STEP_DIV),
        .SCAN_DIV(SCAN_DIV),
        .CHAR_W  (CHAR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.shift_en === 1'b1) sen_cnt++;
        if (bus.load === 1'b1) ld_cnt++;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.btn_pause  = 1'b0;
        bus.btn_step   = 1'b0;
        bus.btn_dir    = 1'b0;
        bus.btn_reload = 1'b0;
        bus.char0      = 4'd2;
        bus.char1      = 4'd3;
        bus.char2      = 4'd1;
        bus.char3      = 4'd4;
        repeat (2) tick();

        chk("rst_state", 8'(bus.state), 8'd0);
        chk("rst_shift_en", 8'(bus.shift_en), 8'd0);
        chk("rst_load", 8'(bus.load), 8'd0);
        chk("rst_shift_dir", 8'(bus.shift_dir), 8'd0);
        chk("rst_digit_sel", 8'(bus.digit_sel), 8'b1110);
        chk("rst_digit_code", 8'(bus.digit_code), 8'd0);

        // Reset release: IDLE -> LOAD -> RUN, strobes, and the digit scan
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("boot_state", 8'(bus.state), 8'(exp_st[k]));
            chk("boot_load", 8'(bus.load), 8'(exp_ld[k]));
            chk("boot_shift_en", 8'(bus.shift_en), 8'(exp_sen[k]));
            chk("boot_digit_sel", 8'(bus.digit_sel), 8'(exp_sel[k]));
            chk("boot_digit_code", 8'(bus.digit_code), 8'(exp_cod[k]));
        end
        chk("boot_shift_dir", 8'(bus.shift_dir), 8'd0);

        // Pause in RUN: state changes on the third edge after the press
        bus.btn_pause = 1'b1;
        tick();
        tick();
        chk("pause_latency", 8'(bus.state), 8'd2);
        tick();
        chk("pause_state", 8'(bus.state), 8'd3);
        chk("pause_shift_en", 8'(bus.shift_en), 8'd0);
        bus.btn_pause = 1'b0;
        sen_cnt = 0;
        repeat (6) tick();
        chk("pause_hold_strobes", 8'(sen_cnt), 8'd0);
        chk("pause_hold_state", 8'(bus.state), 8'd3);

        // Two single steps while paused
        sen_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            bus.btn_step = 1'b1;
            tick();
            tick();
            chk("step_early", 8'(bus.shift_en), 8'd0);
            tick();
            chk("step_strobe", 8'(bus.shift_en), 8'd1);
            chk("step_state", 8'(bus.state), 8'd3);
            bus.btn_step = 1'b0;
            tick();
            chk("step_single", 8'(bus.shift_en), 8'd0);
            tick();
            tick();
        end
        chk("step_count", 8'(sen_cnt), 8'd2);

        // Resume: next strobe 4 cycles after re-entering RUN
        sen_cnt = 0;
        bus.btn_pause = 1'b1;
        repeat (3) tick();
        chk("resume_state", 8'(bus.state), 8'd2);
        bus.btn_pause = 1'b0;
        repeat (3) tick();
        chk("resume_quiet", 8'(sen_cnt), 8'd0);
        tick();
        chk("resume_first_step", 8'(bus.shift_en), 8'd1);

        // Direction toggle in RUN
        bus.btn_dir = 1'b1;
        tick();
        tick();
        chk("dir_before", 8'(bus.shift_dir), 8'd0);
        tick();
        chk("dir_after", 8'(bus.shift_dir), 8'd1);
        chk("dir_no_strobe", 8'(bus.shift_en), 8'd0);
        bus.btn_dir = 1'b0;
        tick();
        chk("dir_strobe", 8'(bus.shift_en), 8'd1);
        chk("dir_strobe_dir", 8'(bus.shift_dir), 8'd1);
        repeat (4) tick();
        chk("dir_keep_strobe", 8'(bus.shift_en), 8'd1);
        chk("dir_keep_dir", 8'(bus.shift_dir), 8'd1);

        // Priority: reload + pause + step together
        sen_cnt = 0;
        ld_cnt  = 0;
        bus.btn_reload = 1'b1;
        bus.btn_pause  = 1'b1;
        bus.btn_step   = 1'b1;
        repeat (3) tick();
        chk("prio_state_load", 8'(bus.state), 8'd1);
        chk("prio_load", 8'(bus.load), 8'd1);
        chk("prio_no_strobe", 8'(bus.shift_en), 8'd0);
        bus.btn_reload = 1'b0;
        bus.btn_pause  = 1'b0;
        bus.btn_step   = 1'b0;
        tick();
        chk("prio_state_run", 8'(bus.state), 8'd2);
        chk("prio_load_off", 8'(bus.load), 8'd0);
        repeat (3) tick();
        chk("prio_still_run", 8'(bus.state), 8'd2);
        chk("prio_strobes", 8'(sen_cnt), 8'd0);
        chk("prio_load_count", 8'(ld_cnt), 8'd1);
        tick();
        chk("prio_first_step", 8'(bus.shift_en), 8'd1);

        // Direction pulse landing in LOAD is ignored
        bus.btn_reload = 1'b1;
        tick();
        bus.btn_dir = 1'b1;
        tick();
        tick();
        chk("ldir_state_load", 8'(bus.state), 8'd1);
        chk("ldir_dir_load", 8'(bus.shift_dir), 8'd1);
        tick();
        chk("ldir_state_run", 8'(bus.state), 8'd2);
        chk("ldir_dir_run", 8'(bus.shift_dir), 8'd1);
        bus.btn_reload = 1'b0;
        bus.btn_dir    = 1'b0;
        tick();
        chk("ldir_dir_hold", 8'(bus.shift_dir), 8'd1);
        tick();

        // Scan: character change shows on the next digit-2 slot, then 1 clk later
        bus.char2 = 4'd5;
        n = 0;
        while (bus.digit_sel === 4'b1011 && n < 16) begin
            tick();
            n++;
        end
        while (bus.digit_sel !== 4'b1011 && n < 16) begin
            tick();
            n++;
        end
        chk("scan_slot_found", 8'(n < 16), 8'd1);
        chk("scan_code_new", 8'(bus.digit_code), 8'd5);
        bus.char2 = 4'd6;
        tick();
        chk("scan_sel_same_slot", 8'(bus.digit_sel), 8'b1011);
        chk("scan_code_follow", 8'(bus.digit_code), 8'd6);

        // Mid-run reset during a strobe with a pause pulse pending
        n = 0;
        tick();
        while (bus.shift_en !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk("mrst_find_strobe", 8'(bus.shift_en), 8'd1);
        tick();
        tick();
        bus.btn_pause = 1'b1;
        tick();
        tick();
        chk("mrst_pre_strobe", 8'(bus.shift_en), 8'd1);
        rst_n = 1'b0;
        bus.btn_pause = 1'b0;
        #1;
        chk("mrst_state", 8'(bus.state), 8'd0);
        chk("mrst_shift_en", 8'(bus.shift_en), 8'd0);
        chk("mrst_load", 8'(bus.load), 8'd0);
        chk("mrst_digit_sel", 8'(bus.digit_sel), 8'b1110);
        chk("mrst_digit_code", 8'(bus.digit_code), 8'd0);
        chk("mrst_shift_dir", 8'(bus.shift_dir), 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_boot_load_state", 8'(bus.state), 8'd1);
        chk("mrst_boot_load", 8'(bus.load), 8'd1);
        tick();
        chk("mrst_boot_run", 8'(bus.state), 8'd2);
        chk("mrst_boot_load_off", 8'(bus.load), 8'd0);
        sen_cnt = 0;
        repeat (3) tick();
        chk("mrst_boot_quiet", 8'(sen_cnt), 8'd0);
        tick();
        chk("mrst_boot_step", 8'(bus.shift_en), 8'd1);
        chk("mrst_no_pause", 8'(bus.state), 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/marquee_ctrl.md
Name: marquee_ctrl

Overview:
- Sequencer and display scheduler for the 8-character rotating marquee register.
- Decides when the rotating register loads its initial message, when it rotates and in which direction, driven by debounced user buttons.
- Time-shares the single seven-segment code bus among the 4 visible digits.
- Sits between the board buttons and the shift datapath / seven-segment decoder.

Parameters:
- STEP_DIV, 25000000, clk cycles per rotation step in RUN; minimum 2.
- SCAN_DIV, 100000, clk cycles each digit is held active; minimum 2.
- CHAR_W, 4, width of one character code.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_pause  in  1  level input from a debounced button; its rising edge toggles run/pause.
- btn_step  in  1  level input; its rising edge requests a single step while paused.
- btn_dir  in  1  level input; its rising edge toggles the rotation direction.
- btn_reload  in  1  level input; its rising edge reloads the initial message.
- char0..char3  in  CHAR_W each  visible character codes from the datapath.
- shift_en  out  1  one-cycle rotate strobe to the datapath.
- shift_dir  out  1  rotation direction: 0 = left (bit7 to bit0 wrap), 1 = right.
- load  out  1  one-cycle strobe that makes the datapath reload its initial value.
- digit_sel  out  4  active-low one-hot digit enable.
- digit_code  out  CHAR_W  code for the currently enabled digit.
- state  out  2  FSM state, for debug.

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low. While reset is asserted:
  - state = IDLE (2'd0).
  - shift_en = 0, load = 0, shift_dir = 0.
  - digit_sel = 4'b1110, digit_code = 0.
  - All counters, synchronizer flops and edge-detect flops are cleared to 0.
- Button inputs:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge becomes visible 3 clk after the input rises; this is the edge pulse.
  - An input held high produces exactly one pulse.
- FSM encoding: IDLE = 0, LOAD = 1, RUN = 2, PAUSE = 3.
  - IDLE: unconditionally goes to LOAD on the next clk.
  - LOAD: load = 1 for exactly this one cycle, then goes to RUN.
  - RUN: on a pause pulse, go to PAUSE.
  - PAUSE: on a pause pulse, go to RUN.
  - RUN or PAUSE: on a reload pulse, go to LOAD.
- Simultaneous button pulses, priority order:
  1. reload
  2. pause
  3. step
  - Lower-priority pulses arriving in the same cycle are discarded, not queued.
  - A dir pulse is independent of this priority: it toggles shift_dir in any state except LOAD and IDLE, where it is ignored.
- Step counter:
  - Counts only in RUN, from 0 to STEP_DIV-1.
  - At STEP_DIV-1: shift_en = 1 for that cycle (registered), and the counter wraps to 0.
  - The counter is forced to 0 in every other state, so the first step after entering RUN occurs STEP_DIV cycles later.
- Single step: a step pulse in PAUSE gives shift_en = 1 for exactly one cycle; the state remains PAUSE. A step pulse in RUN is ignored.
- shift_dir timing:
  - shift_dir changes in the cycle after the dir pulse.
  - A shift_en in that same cycle already uses the new direction.
  - shift_dir is not cleared by reload.
- shift_en and load are never high in the same cycle.
- Display scan:
  - The scan counter runs 0..SCAN_DIV-1 in every state except reset.
  - A 2-bit digit index increments on each scan counter wrap (3 wraps to 0).
  - digit_sel is registered and equals ~(4'b0001 << idx).
  - digit_code is registered each cycle as char[idx_next], where idx_next is the index value being loaded that cycle. This keeps digit_sel and digit_code aligned with no skew cycle.
  - When char inputs change, digit_code follows 1 clk later.
- Reset mid-operation: all outputs return to their reset values immediately.
  - A pending step, pause or reload pulse is lost.
  - After release, the block re-executes the IDLE→LOAD sequence.

Test Plan:
(All scenarios use STEP_DIV=4, SCAN_DIV=2, CHAR_W=4.)
- Reset release: deassert rst_n → state goes 0 → 1 → 2; load=1 for exactly 1 cycle; first shift_en 4 cycles after entering RUN, then every 4 cycles; shift_dir=0.
- Pause/step: pulse btn_pause in RUN → state=3 after 3-cycle sync latency and shift_en stops; pulse btn_step twice → exactly two single-cycle shift_en; pulse btn_pause again → RUN, with the next shift_en 4 cycles later.
- Priority: raise btn_reload, btn_pause and btn_step in the same cycle while in RUN → state goes to LOAD (load=1 once), then RUN; no PAUSE, and no extra shift_en.
- Direction: pulse btn_dir in RUN → shift_dir=1 from the next cycle, and subsequent shift_en pulses keep shift_dir=1; pulse btn_dir in LOAD → no change.
- Scan: char0..3 = 2, 3, 1, 4 → digit_sel cycles 1110, 1101, 1011, 0111, changing every 2 cycles, with digit_code = 2, 3, 1, 4 aligned to the same cycles; change char2 to 5 → digit_code shows 5 on the next digit-2 slot.
- Mid-run reset: assert rst_n low between steps → shift_en=0, digit_sel=1110 and state=0 in the same cycle; after release the full load sequence repeats.
